// File: rtl/pla_vec_feeder_if.sv
// pla_vec_feeder_if -- handshake bundle for pla_vec_feeder.
//   in_valid/in_ready/in_vec : single-vector request channel (master -> slave)
//   out_valid/out_ready      : result channel (slave -> master)
//   out_vec/out_y/out_par    : result payload (vector, sampled y0, parity)
// NBITS must match the NBITS of the attached pla_vec_feeder.
interface pla_vec_feeder_if #(
  parameter int unsigned NBITS = 17
);
  logic             in_valid;
  logic             in_ready;
  logic [NBITS-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [NBITS-1:0] out_vec;
  logic             out_y;
  logic             out_par;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_vec, out_y, out_par
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_vec, out_y, out_par
  );
endinterface

// File: rtl/pla_vec_feeder.sv
// pla_vec_feeder -- drives input vectors to a combinational PLA cube stage
// and samples its y0 output, either one requested vector at a time or as an
// exhaustive sweep of all 2^NBITS vectors.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : request an exhaustive sweep (honoured only in IDLE)
//   bus       : pla_vec_feeder_if.slave (single-vector request + result)
//   x         : registered vector to cube inputs x0..x(NBITS-1)
//   y0        : combinational cube output returned from downstream
//   busy      : high whenever not IDLE
//   done      : one-cycle pulse in FIN at the end of a sweep
//   hit_cnt   : saturating count of sampled y0==1 events
// Build option: define PLA_FEEDER_PARITY_EN to drive out_par as the even
// parity of {out_vec, out_y}; otherwise out_par is tied to 0.
module pla_vec_feeder #(
  parameter int unsigned NBITS = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  pla_vec_feeder_if.slave    bus,
  output logic [NBITS-1:0]   x,
  input  logic               y0,
  output logic               busy,
  output logic               done,
  output logic [NBITS:0]     hit_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    EMIT,
    SWEEP,
    FIN
  } state_e;

  localparam logic [NBITS-1:0] X_ONE   = NBITS'(1);
  localparam logic [NBITS:0]   HIT_ONE = (NBITS + 1)'(1);

  state_e           state_q;
  logic [NBITS-1:0] x_q;
  logic [NBITS-1:0] out_vec_q;
  logic             out_y_q;
  logic             out_valid_q;
  logic             done_q;
  logic [NBITS:0]   hit_cnt_q;
`ifdef PLA_FEEDER_PARITY_EN
  logic             out_par_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      out_vec_q   <= '0;
      out_y_q     <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      hit_cnt_q   <= '0;
`ifdef PLA_FEEDER_PARITY_EN
      out_par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          // start has priority; a coincident in_valid is left unaccepted
          if (start) begin
            state_q   <= SWEEP;
            x_q       <= '0;
            hit_cnt_q <= '0;
          end else if (bus.in_valid) begin
            state_q <= SAMPLE;
            x_q     <= bus.in_vec;
          end
        end
        SAMPLE: begin
          out_vec_q   <= x_q;
          out_y_q     <= y0;
          out_valid_q <= 1'b1;
`ifdef PLA_FEEDER_PARITY_EN
          out_par_q   <= ^{x_q, y0};
`endif
          if (y0 && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + HIT_ONE;
          state_q <= EMIT;
        end
        EMIT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        SWEEP: begin
          if (y0 && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + HIT_ONE;
          // last vector is sampled at all-ones; x stops there instead of wrapping
          if (x_q == '1) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end else begin
            x_q <= x_q + X_ONE;
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign x             = x_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign hit_cnt       = hit_cnt_q;
  assign bus.in_ready  = (state_q == IDLE) && !start;
  assign bus.out_valid = out_valid_q;
  assign bus.out_vec   = out_vec_q;
  assign bus.out_y     = out_y_q;
`ifdef PLA_FEEDER_PARITY_EN
  assign bus.out_par   = out_par_q;
`else
  assign bus.out_par   = 1'b0;
`endif

endmodule

// File: doc/pla_vec_feeder.md
PLA_VEC_FEEDER -- requirements
Module: pla_vec_feeder

Interface
REQ-001 SHALL have parameter NBITS, default 17, giving the width of the PLA input vector driven to the cube stage.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request for an exhaustive sweep of all 2^NBITS input vectors.
REQ-005 SHALL have port in_valid  input  1  single-vector request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a single vector.
REQ-007 SHALL have port in_vec  input  NBITS  vector to apply; bit i maps to cube input xi.
REQ-008 SHALL have port x  output  NBITS  registered vector driven to the cube inputs x0..x(NBITS-1).
REQ-009 SHALL have port y0  input  1  combinational cube output, returned from the downstream stage.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port out_vec  output  NBITS  vector that produced the result.
REQ-013 SHALL have port out_y  output  1  sampled y0 for out_vec.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse when a sweep completes.
REQ-016 SHALL have port hit_cnt  output  NBITS+1  count of sampled y0==1 events.
REQ-017 SHALL have port out_par  output  1  result parity (see Configuration).

Function
REQ-018 SHALL implement the states IDLE, SAMPLE, EMIT, SWEEP and FIN.
REQ-019 SHALL assert in_ready only in IDLE when start is low.
REQ-020 SHALL, from IDLE, go to SWEEP on start==1, clear hit_cnt and load x=0; start SHALL win over a simultaneous in_valid, which is left unaccepted.
REQ-021 SHALL, in IDLE on in_valid&in_ready (cycle N), load x=in_vec and go to SAMPLE at cycle N+1.
REQ-022 SHALL, in SAMPLE, capture out_y=y0 and out_vec=x at the end of cycle N+1 and go to EMIT.
REQ-023 SHALL assert out_valid throughout EMIT, from cycle N+2, with out_vec and out_y held stable until out_valid&out_ready.
REQ-024 SHALL, on the out_valid&out_ready handshake cycle, return to IDLE; the next vector is accepted one cycle later at the earliest.
REQ-025 SHALL, in SWEEP, sample y0 every cycle for the current x, increment hit_cnt when y0==1, and increment x by 1.
REQ-026 SHALL, in SWEEP, sample the last vector at x==all-ones and then go to FIN without wrapping x; x SHALL hold all-ones in FIN.
REQ-027 SHALL assert done for exactly the one FIN cycle, then return to IDLE; a sweep SHALL take exactly 2^NBITS SWEEP cycles.
REQ-028 SHALL never assert out_valid during SWEEP or FIN.
REQ-029 SHALL increment hit_cnt in single-vector mode when the captured y0==1, saturating at all-ones in both modes.
REQ-030 SHALL ignore start and in_valid in every state other than IDLE.
REQ-031 SHALL hold x unchanged in IDLE and EMIT.

Reset
REQ-032 SHALL, on rst==1 at a clock edge, force state IDLE, x=0, out_vec=0, out_y=0, out_valid=0, done=0, hit_cnt=0 and out_par=0.
REQ-033 SHALL abort any sweep or pending result when rst is asserted mid-operation, with no done pulse and the result discarded.
REQ-034 SHALL give rst priority over start, in_valid and out_ready.

Configuration
REQ-035 SHALL, with macro PLA_FEEDER_PARITY_EN defined, drive out_par as the even parity (XOR) of {out_vec, out_y}, registered together with them.
REQ-036 SHALL, without PLA_FEEDER_PARITY_EN, drive out_par constant 0 and instantiate no parity logic.

Verification
Bench cube model: y0 = (x == 17'h1FA59).

REQ-037 SHALL cover: single vector 17'h1FA59 accepted at cycle N -> out_valid at N+2 with out_vec=17'h1FA59, out_y=1 and hit_cnt=1.
REQ-038 SHALL cover: single vector 17'h1FA58 with out_ready held low for 5 cycles -> out_valid stays high with out_vec and out_y stable, out_y=0, hit_cnt unchanged, in_ready=0 throughout.
REQ-039 SHALL cover: start pulse -> exactly 131072 SWEEP cycles, then a one-cycle done, hit_cnt=1 and x=17'h1FFFF, with no out_valid at any time.
REQ-040 SHALL cover: start and in_valid high in the same IDLE cycle -> sweep begins, in_ready=0 and the vector is not accepted.
REQ-041 SHALL cover: rst asserted at sweep cycle 1000 -> next cycle in IDLE with x=0, hit_cnt=0 and no done pulse.
REQ-042 SHALL cover: with PLA_FEEDER_PARITY_EN, vector 17'h1FA59 -> out_par=0 (11 ones in the vector plus out_y=1 gives even parity); without the macro -> out_par=0 for every result.
